// File: rtl/sram_bank_bridge_if.sv
// picorv32 native memory bus as seen by the SRAM bridge.
// The master drives the request, the slave returns data, ready and the out-of-range flag.
interface sram_bank_bridge_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        oob_err;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready, oob_err
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready, oob_err
  );
endinterface

// File: rtl/sram_bank_bridge.sv
// picorv32 bus to NUM_BANKS x 4 byte-lane sram_8_1024 macros; fixed 3-cycle access (accept, WAIT, RESP).
// No backpressure: a request is taken in IDLE and mem_valid is ignored until the RESP cycle has passed.
module sram_bank_bridge #(
  parameter int unsigned NUM_BANKS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_bank_bridge_if.slave          bus,
  output logic [NUM_BANKS*4-1:0]     sram_csb0_o,
  output logic [NUM_BANKS*4-1:0]     sram_web0_o,
  output logic [9:0]                 sram_addr0_o,
  output logic [31:0]                sram_din0_o,
  input  logic [NUM_BANKS*32-1:0]    sram_dout0_i
);

  localparam int unsigned BW  = $clog2(NUM_BANKS);
  localparam int unsigned BIW = (BW == 0) ? 1 : BW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic            wr_q;
  logic            in_range_q;
  logic [BIW-1:0]  bank_q;
  logic            ready_q;
  logic            oob_q;
  logic [31:0]     rdata_q;

  logic            accept;
  logic            wr;
  logic            in_range;
  logic [BIW-1:0]  bank;
  logic [31:0]     bank_dout;
  logic            unused_ok;

  assign wr        = |bus.mem_wstrb;
  assign in_range  = (bus.mem_addr >> (12 + BW)) == (BASE_ADDR >> (12 + BW));
  assign bank      = BIW'((bus.mem_addr >> 12) & (NUM_BANKS - 1));
  assign accept    = (state_q == S_IDLE) && bus.mem_valid && !rst;
  assign bank_dout = sram_dout0_i[32*bank_q +: 32];
  assign unused_ok = ^{bus.mem_instr, bus.mem_addr[1:0]};

  assign sram_addr0_o = bus.mem_addr[11:2];
  assign sram_din0_o  = bus.mem_wdata;

  // Macros latch their inputs on the accepting edge, so they are driven only in that cycle.
  always_comb begin
    sram_csb0_o = '1;
    sram_web0_o = '1;
    if (accept && in_range) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank == BIW'(b)) begin
          for (int n = 0; n < 4; n++) begin
            if (!wr || bus.mem_wstrb[n]) begin
              sram_csb0_o[b*4+n] = 1'b0;
              sram_web0_o[b*4+n] = !wr;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      bank_q     <= '0;
      ready_q    <= 1'b0;
      oob_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mem_valid) begin
            wr_q       <= wr;
            in_range_q <= in_range;
            bank_q     <= bank;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          rdata_q <= (in_range_q && !wr_q) ? bank_dout : 32'h0;
          ready_q <= 1'b1;
          oob_q   <= !in_range_q;
          state_q <= S_RESP;
        end
        S_RESP: begin
          ready_q <= 1'b0;
          oob_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.oob_err   = oob_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_sram_bank_bridge.sv
// Two bridges (2 banks at 0, 1 bank at 0x10000) over behavioural sram macros, checked against a word-level memory model.
module tb_sram_bank_bridge;
  localparam int          NBA   = 2;
  localparam logic [31:0] BASEA = 32'h0000_0000;
  localparam int          NBB   = 1;
  localparam logic [31:0] BASEB = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  logic        va, vb;

  sram_bank_bridge_if ifa ();
  sram_bank_bridge_if ifb ();

  assign ifa.mem_valid = va;
  assign ifa.mem_instr = 1'b0;
  assign ifa.mem_addr  = t_addr;
  assign ifa.mem_wdata = t_wdata;
  assign ifa.mem_wstrb = t_wstrb;
  assign ifb.mem_valid = vb;
  assign ifb.mem_instr = 1'b1;
  assign ifb.mem_addr  = t_addr;
  assign ifb.mem_wdata = t_wdata;
  assign ifb.mem_wstrb = t_wstrb;

  logic [7:0]  csb_a, web_a;
  logic [9:0]  adr_a;
  logic [31:0] din_a;
  logic [63:0] dout_a;
  logic [3:0]  csb_b, web_b;
  logic [9:0]  adr_b;
  logic [31:0] din_b;
  logic [31:0] dout_b;

  sram_bank_bridge #(.NUM_BANKS(NBA), .BASE_ADDR(BASEA)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .sram_csb0_o(csb_a), .sram_web0_o(web_a), .sram_addr0_o(adr_a),
    .sram_din0_o(din_a), .sram_dout0_i(dout_a)
  );

  sram_bank_bridge #(.NUM_BANKS(NBB), .BASE_ADDR(BASEB)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .sram_csb0_o(csb_b), .sram_web0_o(web_b), .sram_addr0_o(adr_b),
    .sram_din0_o(din_b), .sram_dout0_i(dout_b)
  );

  // Byte-lane macros: inputs captured on the rising edge, read data registered.
  logic [7:0] mac_a [8][1024];
  logic [7:0] mac_b [4][1024];

  always @(posedge clk) begin
    for (int m = 0; m < 8; m++)
      if (!csb_a[m]) begin
        if (!web_a[m]) mac_a[m][adr_a] <= din_a[(m%4)*8 +: 8];
        else           dout_a[m*8 +: 8] <= mac_a[m][adr_a];
      end
    for (int m = 0; m < 4; m++)
      if (!csb_b[m]) begin
        if (!web_b[m]) mac_b[m][adr_b] <= din_b[m*8 +: 8];
        else           dout_b[m*8 +: 8] <= mac_b[m][adr_b];
      end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] ref_m [2][2048];
  logic [31:0] pool  [2][16];
  bit          burst;
  int          last_d;

  function automatic int unsigned nbk(input int d);
    return (d != 0) ? NBB : NBA;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d != 0) ? BASEB : BASEA;
  endfunction

  // One complete access on DUT d; leaves mem_valid high so a following call is back-to-back.
  task automatic acc(input int d, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] win, erd;
    int unsigned bk, widx;
    bit          inr, eoob;
    logic [7:0]  ecsb, eweb, gcsb, gweb;
    logic        r, o;
    int          acc_c, lat;

    win  = nbk(d) * 4096;
    inr  = (addr / win) == (base_of(d) / win);
    bk   = (addr / 4096) % nbk(d);
    widx = (addr % win) / 4;
    ecsb = 8'hFF;
    eweb = 8'hFF;
    if (inr)
      for (int n = 0; n < 4; n++)
        if (strb == 4'h0 || strb[n]) begin
          ecsb[bk*4+n] = 1'b0;
          if (strb != 4'h0) eweb[bk*4+n] = 1'b0;
        end
    erd  = (inr && strb == 4'h0) ? ref_m[d][widx] : 32'h0;
    eoob = !inr;
    if (inr)
      for (int n = 0; n < 4; n++)
        if (strb[n]) ref_m[d][widx][8*n +: 8] = wd[8*n +: 8];

    acc_c   = (burst && last_d == d) ? 1 : 0;
    t_addr  = addr;
    t_wdata = wd;
    t_wstrb = strb;
    va      = (d == 0);
    vb      = (d == 1);
    lat     = -1;
    rd      = 32'h0;
    o       = 1'b0;
    for (int c = 0; c <= 8 && lat < 0; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      gcsb = (d != 0) ? {4'hF, csb_b} : csb_a;
      gweb = (d != 0) ? {4'hF, web_b} : web_a;
      if (c == acc_c) begin
        chk("csb_sel", gcsb, ecsb);
        chk("web_sel", gweb, eweb);
      end
      if (c == acc_c + 1) chk("csb_after", gcsb, 8'hFF);
      r = (d != 0) ? ifb.mem_ready : ifa.mem_ready;
      if (c > 0 && r) begin
        lat = c;
        rd  = (d != 0) ? ifb.mem_rdata : ifa.mem_rdata;
        o   = (d != 0) ? ifb.oob_err : ifa.oob_err;
      end
    end
    chk("latency", lat, acc_c + 2);
    if (lat >= 0) begin
      chk("rdata", rd, erd);
      chk("oob_err", o, eoob);
    end
    burst  = 1'b1;
    last_d = d;
  endtask

  task automatic idle(input int n);
    logic r;
    va = 1'b0;
    vb = 1'b0;
    @(negedge clk);
    r = (last_d != 0) ? ifb.mem_ready : ifa.mem_ready;
    if (burst) chk("ready_pulse", r, 1'b0);
    repeat (n - 1) @(negedge clk);
    burst = 1'b0;
  endtask

  // Reset lands in the WAIT cycle of a write; rewrites the stored word so memory is unaffected either way.
  task automatic abort_test();
    logic seen;
    t_addr  = 32'h20;
    t_wdata = ref_m[0][8];
    t_wstrb = 4'hF;
    va      = 1'b1;
    vb      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    va  = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    seen = ifa.mem_ready;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ifa.mem_ready;
    end
    chk("abort_no_ready", seen, 1'b0);
    burst = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] a;
  logic [3:0]  s;
  int          d;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2048; j++) ref_m[i][j] = 32'h0;
    pool[0][0] = 32'h10;
    pool[0][1] = 32'h20;
    pool[0][2] = 32'hFFC;
    pool[0][3] = 32'h1000;
    for (int i = 4; i < 16; i++) pool[0][i] = ($urandom % 2048) * 4;
    pool[1][0] = BASEB;
    for (int i = 1; i < 16; i++) pool[1][i] = BASEB + ($urandom % 1024) * 4;

    burst   = 1'b0;
    last_d  = 0;
    rst     = 1'b1;
    va      = 1'b1;
    vb      = 1'b0;
    t_addr  = 32'h10;
    t_wdata = 32'hDEADBEEF;
    t_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", ifa.mem_ready, 1'b0);
      chk("rst_rdata", ifa.mem_rdata, 32'h0);
      chk("rst_csb", {csb_b, csb_a}, 12'hFFF);
    end
    rst = 1'b0;

    acc(0, 32'h10, 4'hF, 32'hDEADBEEF, rd);
    acc(0, 32'h10, 4'h0, 32'h0, rd);
    chk("full_word_rd", rd, 32'hDEADBEEF);
    idle(2);

    acc(0, 32'h20, 4'hF, 32'h11223344, rd);
    acc(0, 32'h20, 4'b0101, 32'hAABBCCDD, rd);
    acc(0, 32'h20, 4'h0, 32'h0, rd);
    chk("partial_rd", rd, 32'h11BB33DD);
    idle(1);

    acc(0, 32'hFFC, 4'hF, 32'h1, rd);
    acc(0, 32'h1000, 4'hF, 32'h2, rd);
    acc(0, 32'hFFC, 4'h0, 32'h0, rd);
    chk("bank0_top", rd, 32'h1);
    acc(0, 32'h1000, 4'h0, 32'h0, rd);
    chk("bank1_bot", rd, 32'h2);
    idle(1);

    acc(1, 32'h0002_0000, 4'h0, 32'h0, rd);
    acc(1, BASEB, 4'hF, 32'hCAFEF00D, rd);
    acc(1, 32'h0000_0000, 4'hF, 32'h12345678, rd);
    acc(1, BASEB, 4'h0, 32'h0, rd);
    chk("oob_no_write", rd, 32'hCAFEF00D);
    idle(2);

    acc(0, 32'h10, 4'h0, 32'h0, rd);
    acc(0, 32'h20, 4'h0, 32'h0, rd);
    acc(0, 32'hFFC, 4'h0, 32'h0, rd);
    acc(0, 32'h1000, 4'h0, 32'h0, rd);
    idle(2);

    abort_test();
    acc(0, 32'h20, 4'h0, 32'h0, rd);
    chk("after_abort", rd, 32'h11BB33DD);
    idle(1);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) acc(k, pool[k][i], 4'hF, $urandom, rd);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      d = int'($urandom % 2);
      a = pool[d][$urandom % 16];
      if ($urandom % 8 == 0) a = a ^ ($urandom_range(1, 255) << ((d == 0) ? 13 : 12));
      s = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
      acc(d, a, s, $urandom, rd);
      if ($urandom % 4 == 0) idle(1 + int'($urandom % 2));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
